// File: rtl/cpu_pkg.sv
// Shared RV32 core types: per-boundary pipeline payload structs, their
// flattened widths, and the occupancy type used by pipe_stage_reg.
package cpu_pkg;

  // IF/ID: fetched instruction and its address.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // ID/EX control: WB, M and EX groups.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } id_ex_ctrl_t;

  // ID/EX data: operand B already carries the immediate when alu_src selects it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } id_ex_data_t;

  // EX/MEM control: WB and M groups.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
  } ex_mem_data_t;

  // MEM/WB control: WB group only.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  rd;
  } mem_wb_data_t;

  localparam int IF_ID_W       = $bits(if_id_t);
  localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int ID_EX_DATA_W  = $bits(id_ex_data_t);
  localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
  localparam int EX_MEM_DATA_W = $bits(ex_mem_data_t);
  localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
  localparam int MEM_WB_DATA_W = $bits(mem_wb_data_t);

  // Number of entries held by a pipeline register (0..2).
  typedef logic [1:0] pipe_occ_t;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid flag plus an opaque ctrl/data payload.
// Clear has priority over load.
module pipe_slot #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Valid flag: set on load, dropped on clear, lost immediately on reset.
  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_valid <= 1'b0;
    else if (i_clear) r_valid <= 1'b0;
    else if (i_load)  r_valid <= 1'b1;
  end

  // Payload capture on load.
  // NOTE: payload has no reset; r_valid alone says whether it is meaningful.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register with valid/ready handshake, stall,
// flush-to-bubble and an optional 2-entry skid buffer (FIFO order).
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int              CTRL_W      = ID_EX_CTRL_W,
  parameter int              DATA_W      = ID_EX_DATA_W,
  parameter bit              SKID        = 1'b1,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              stall,
  input  logic              flush,
  output pipe_occ_t         occupancy,
  output logic [15:0]       stall_cnt
);

  logic              w_enq;
  logic              w_deq;
  logic              w_main_valid;
  logic              w_skid_valid;
  logic              w_main_load;
  logic              w_main_clear;
  logic [CTRL_W-1:0] w_main_d_ctrl;
  logic [DATA_W-1:0] w_main_d_data;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [15:0]       r_stall_cnt;

  assign w_enq = in_valid & in_ready;
  assign w_deq = w_main_valid & out_ready & ~stall;

  // The main slot is always the head presented downstream.
  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_ctrl  (w_main_d_ctrl),
    .i_data  (w_main_d_data),
    .o_valid (w_main_valid),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic              w_skid_load;
      logic              w_skid_clear;
      logic [CTRL_W-1:0] w_skid_ctrl;
      logic [DATA_W-1:0] w_skid_data;

      // Second entry; only ever written from the upstream port.
      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
      );

      // Space remains unless the skid slot is occupied; comes straight off a flop.
      assign in_ready = ~w_skid_valid;

      // Slot steering: flush kills both, a dequeue shifts skid to main,
      // a new entry fills the first free slot behind the head.
      // NOTE: every output gets a default first so no latch is inferred.
      always_comb begin
        w_main_load   = 1'b0;
        w_main_clear  = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_clear  = 1'b0;
        w_main_d_ctrl = in_ctrl;
        w_main_d_data = in_data;
        if (flush) begin
          w_main_clear = 1'b1;
          w_skid_clear = 1'b1;
        end else if (w_deq && w_skid_valid) begin
          w_main_load   = 1'b1;
          w_main_d_ctrl = w_skid_ctrl;
          w_main_d_data = w_skid_data;
          if (w_enq) w_skid_load  = 1'b1;
          else       w_skid_clear = 1'b1;
        end else if (w_deq) begin
          if (w_enq) w_main_load  = 1'b1;
          else       w_main_clear = 1'b1;
        end else if (w_enq) begin
          if (w_main_valid) w_skid_load = 1'b1;
          else              w_main_load = 1'b1;
        end
      end
    end else begin : g_single
      assign w_skid_valid = 1'b0;
      // Accept when empty or when the head leaves this same cycle.
      assign in_ready     = ~w_main_valid | (out_ready & ~stall);

      // Single-slot steering: flush kills, enqueue overwrites, dequeue empties.
      always_comb begin
        w_main_load   = 1'b0;
        w_main_clear  = 1'b0;
        w_main_d_ctrl = in_ctrl;
        w_main_d_data = in_data;
        if (flush)      w_main_clear = 1'b1;
        else if (w_enq) w_main_load  = 1'b1;
        else if (w_deq) w_main_clear = 1'b1;
      end
    end
  endgenerate

  // Count cycles where the head is presented but not taken; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_main_valid && !(out_ready && !stall) && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? w_main_ctrl : BUBBLE_CTRL;
  assign out_data  = w_main_data;
  assign occupancy = pipe_occ_t'({1'b0, w_main_valid} + {1'b0, w_skid_valid});
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: instance 0 has the skid buffer,
// instance 1 is single-entry. A queue-based reference model runs on each
// rising edge; a monitor compares on each falling edge.
module tb_pipe_stage_reg;
  import cpu_pkg::*;

  localparam int CW = ID_EX_CTRL_W;
  localparam int DW = ID_EX_DATA_W;
  localparam int N  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid [N];
  logic          in_ready [N];
  logic [CW-1:0] in_ctrl  [N];
  logic [DW-1:0] in_data  [N];
  logic          out_valid[N];
  logic          out_ready[N];
  logic [CW-1:0] out_ctrl [N];
  logic [DW-1:0] out_data [N];
  logic          stall    [N];
  logic          flush    [N];
  pipe_occ_t     occupancy[N];
  logic [15:0]   stall_cnt[N];

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .BUBBLE_CTRL('0)) u_dut_skid (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
    .stall(stall[0]), .flush(flush[0]), .occupancy(occupancy[0]), .stall_cnt(stall_cnt[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .BUBBLE_CTRL('0)) u_dut_single (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
    .stall(stall[1]), .flush(flush[1]), .occupancy(occupancy[1]), .stall_cnt(stall_cnt[1])
  );

  // Reference model state: entries in flight, saturating stall count.
  logic [CW+DW-1:0] exp_q [N][$];
  int               m_occ [N];
  int               m_cnt [N];
  bit               m_enq [N];
  int               checks   = 0;
  int               failures = 0;
  int               seq      = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Capacity rule: 2 entries with skid (registered), else free or leaving now.
  function automatic logic m_in_ready(input int i);
    if (i == 0) return (m_occ[i] < 2);
    return (m_occ[i] == 0) || (out_ready[i] && !stall[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      m_occ[i] = 0;
      m_cnt[i] = 0;
      m_enq[i] = 1'b0;
    end
  endtask

  // Model: evaluates each edge with the inputs held since the previous edge.
  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          bit enq, deq;
          enq = in_valid[i] && m_in_ready(i);
          deq = (m_occ[i] > 0) && out_ready[i] && !stall[i];
          if ((m_occ[i] > 0) && !(out_ready[i] && !stall[i]) && (m_cnt[i] < 65535)) m_cnt[i]++;
          m_enq[i] = enq && !flush[i];
          if (flush[i]) begin
            exp_q[i].delete();
            m_occ[i] = 0;
          end else begin
            if (enq) exp_q[i].push_back({in_ctrl[i], in_data[i]});
            m_occ[i] = m_occ[i] + int'(enq) - int'(deq);
          end
        end
      end
    end
  end

  // Monitor: compares the presented head and status, pops on a transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < N; i++) begin
          logic [CW+DW-1:0] head;
          check($sformatf("occupancy[%0d]", i), 128'(occupancy[i]), 128'(m_occ[i]));
          check($sformatf("in_ready[%0d]", i), 128'(in_ready[i]), 128'(m_in_ready(i)));
          check($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(exp_q[i].size() != 0));
          check($sformatf("stall_cnt[%0d]", i), 128'(stall_cnt[i]), 128'(m_cnt[i]));
          if (exp_q[i].size() != 0) begin
            head = exp_q[i][0];
            check($sformatf("out_ctrl[%0d]", i), 128'(out_ctrl[i]), 128'(head[CW+DW-1:DW]));
            check($sformatf("out_data[%0d]", i), 128'(out_data[i]), 128'(head[DW-1:0]));
            if (out_ready[i] && !stall[i] && !flush[i]) void'(exp_q[i].pop_front());
          end else begin
            check($sformatf("bubble_ctrl[%0d]", i), 128'(out_ctrl[i]), 128'(0));
          end
        end
      end
    end
  end

  // Drive both instances for a number of cycles with percentage knobs.
  // An offered entry is held until the model says it was taken or flushed.
  task automatic run(input int cycles, input int p_valid, input int p_ready,
                     input int p_stall, input int p_flush);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        logic [127:0] r;
        bit hold;
        hold = in_valid[i] && !m_enq[i] && !flush[i];
        if (!hold) begin
          seq++;
          r           = {$urandom, $urandom, $urandom, 32'(seq)};
          in_valid[i] = ($urandom_range(1, 100) <= p_valid);
          in_ctrl[i]  = CW'($urandom);
          in_data[i]  = r[DW-1:0];
        end
        out_ready[i] = ($urandom_range(1, 100) <= p_ready);
        stall[i]     = ($urandom_range(1, 100) <= p_stall);
        flush[i]     = ($urandom_range(1, 100) <= p_flush);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0; in_ctrl[i] = '0; in_data[i] = '0;
      out_ready[i] = 1'b0; stall[i] = 1'b0; flush[i] = 1'b0;
    end
    #1;
    // Reset values are visible while reset is held, before any clock edge.
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_occ[%0d]", i), 128'(occupancy[i]), 128'(0));
      check($sformatf("rst_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("rst_ctrl[%0d]", i), 128'(out_ctrl[i]), 128'(0));
      check($sformatf("rst_cnt[%0d]", i), 128'(stall_cnt[i]), 128'(0));
      check($sformatf("rst_in_ready[%0d]", i), 128'(in_ready[i]), 128'(1));
    end
    #20;
    @(posedge clk); #2;
    rst_n = 1'b1;

    run(30, 100, 100, 0, 0);   // streaming
    run(6, 100, 0, 0, 0);      // backpressure: fill, upstream holds
    run(12, 0, 100, 0, 0);     // drain in order
    run(1, 100, 0, 0, 0);      // one entry
    run(3, 0, 100, 100, 0);    // stalled with out_ready high
    run(3, 0, 100, 0, 0);      // release
    run(4, 100, 0, 0, 0);      // fill to two entries
    run(1, 100, 0, 0, 100);    // flush with a same-cycle offer
    run(4, 100, 100, 0, 0);
    run(3000, 70, 60, 25, 5);  // mixed random traffic

    // Asynchronous reset in the middle of a cycle with the skid instance full.
    run(4, 100, 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("arst_occ[%0d]", i), 128'(occupancy[i]), 128'(0));
      check($sformatf("arst_valid[%0d]", i), 128'(out_valid[i]), 128'(0));
      check($sformatf("arst_ctrl[%0d]", i), 128'(out_ctrl[i]), 128'(0));
      check($sformatf("arst_cnt[%0d]", i), 128'(stall_cnt[i]), 128'(0));
      in_valid[i] = 1'b0;
      flush[i]    = 1'b0;
    end
    check("arst_in_ready[0]", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #2;
    rst_n = 1'b1;
    run(20, 60, 70, 10, 0);

    // Saturation: a head that is never taken for more than 65535 cycles.
    run(1, 100, 0, 0, 0);
    run(70000, 0, 0, 0, 0);
    #1;
    check("sat_cnt[0]", 128'(stall_cnt[0]), 128'(16'hFFFF));
    check("sat_cnt[1]", 128'(stall_cnt[1]), 128'(16'hFFFF));
    check("single_in_ready_blocked", 128'(in_ready[1]), 128'(0));
    check("single_occ_max", 128'(occupancy[1]), 128'(1));
    run(10, 50, 100, 0, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
